// File: rtl/frame_pkg.sv
// frame_pkg - shared types and helpers for the frame-buffer reader/writer pair.
//   pix_addr_w : address width needed to cover one img_width x img_height frame
//   rd_state_t : reader FSM states
//   pixel_t    : default-width tagged pixel {data, sof, last}
package frame_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             last;
  } pixel_t;

  function automatic int unsigned pix_addr_w(input int unsigned img_width,
                                             input int unsigned img_height);
    return $clog2(img_width * img_height);
  endfunction

endpackage

// File: rtl/small_sync_fifo.sv
// small_sync_fifo - tiny synchronous FIFO, output taken straight from the storage registers.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write strobe and data
//   pop           read strobe (ignored when empty)
//   rdata         head entry (only meaningful when !empty)
//   empty, count  occupancy status
module small_sync_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: consumers qualify rdata with !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/bram_to_stream.sv
// bram_to_stream - reads one IMG_WIDTH x IMG_HEIGHT frame from a BRAM read port on a start
// pulse and emits it as a valid/ready pixel stream in raster order with sof/last tags.
// Reads are credit-limited so every returned word has a FIFO slot; backpressure never
// loses pixels.
// Optional build macro BRAM_TO_STREAM_BINARIZE_EN: y_data becomes all-ones when the
// pixel is >= WHITE_THRESHOLD, else zero (applied at the FIFO output).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       one-cycle pulse, ignored while busy
//   busy, frame_done            frame in progress / one-cycle completion pulse
//   bram_addr, bram_re          BRAM read request
//   bram_rdata                  BRAM data, RD_LATENCY cycles after bram_re
//   y_valid, y_ready, y_data    output pixel stream
//   y_sof, y_last               first / final pixel of the frame
module bram_to_stream
  import frame_pkg::*;
#(
  parameter int unsigned IMG_WIDTH       = 640,
  parameter int unsigned IMG_HEIGHT      = 480,
  parameter int unsigned W               = 8,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned WHITE_THRESHOLD = 180,
  localparam int unsigned AW = pix_addr_w(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic [AW-1:0] bram_addr,
  output logic          bram_re,
  input  logic [W-1:0]  bram_rdata,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [W-1:0]  y_data,
  output logic          y_sof,
  output logic          y_last
);

  localparam int unsigned N          = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         last;
  } tag_pix_t;

  rd_state_t             state_q, state_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  frame_done_q, frame_done_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d, sof_q, sof_d, last_q, last_d;
  logic [CNT_W-1:0]      in_flight, fifo_count;
  logic                  credit, issue, fifo_empty, pop, last_hs;
  tag_pix_t              push_pix, head_pix;
  logic [W-1:0]          pix;

  // Reads in flight plus words already queued must never exceed the FIFO depth.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      in_flight = in_flight + CNT_W'(vld_q[i]);
    end
  end

  assign credit = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue  = (state_q == READ) && credit;

  // Valid/tag shift register aligned with the BRAM read latency.
  always_comb begin
    vld_d     = '0;
    sof_d     = '0;
    last_d    = '0;
    vld_d[0]  = issue;
    sof_d[0]  = issue && (rd_addr_q == '0);
    last_d[0] = issue && (rd_addr_q == LAST_ADDR);
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      vld_d[i]  = vld_q[i-1];
      sof_d[i]  = sof_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  assign pop     = y_valid && y_ready;
  assign last_hs = pop && head_pix.last;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          rd_addr_d = '0;
        end
      end
      READ: begin
        if (issue) begin
          // Hold at the final address rather than wrapping.
          if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
          else                        rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        // The final pixel is the only entry left when it handshakes.
        if (last_hs && (fifo_count == CNT_W'(1)) && (in_flight == '0)) begin
          state_d      = IDLE;
          rd_addr_d    = '0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      frame_done_q <= 1'b0;
      vld_q        <= '0;
      sof_q        <= '0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      frame_done_q <= frame_done_d;
      vld_q        <= vld_d;
      sof_q        <= sof_d;
      last_q       <= last_d;
    end
  end

  assign push_pix.data = bram_rdata;
  assign push_pix.sof  = sof_q[RD_LATENCY-1];
  assign push_pix.last = last_q[RD_LATENCY-1];

  small_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(tag_pix_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (vld_q[RD_LATENCY-1]),
    .wdata(push_pix),
    .pop  (pop),
    .rdata(head_pix),
    .empty(fifo_empty),
    .count(fifo_count)
  );

`ifdef BRAM_TO_STREAM_BINARIZE_EN
  assign pix = (head_pix.data >= W'(WHITE_THRESHOLD)) ? '1 : '0;
`else
  logic unused_thr;
  assign unused_thr = ^WHITE_THRESHOLD;
  assign pix        = head_pix.data;
`endif

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign bram_re    = issue;
  assign bram_addr  = rd_addr_q;
  assign y_valid    = !fifo_empty;
  // Zero the payload when idle so the stream reads as all-zero out of reset.
  assign y_data     = y_valid ? pix : '0;
  assign y_sof      = y_valid && head_pix.sof;
  assign y_last     = y_valid && head_pix.last;

endmodule
